// File: rtl/mul_booth_seq.sv
// Sequential signed 32x32 -> 64 multiplier using radix-2 Booth recoding,
// one recoded multiplier bit per clock, all accumulation through one CLA_64B.

module CLA_64B (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] s
);

  logic [63:0] w_g;
  logic [63:0] w_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // 4-bit lookahead groups; group carries chained, bit carries resolved inside each group
  always_comb begin
    logic [15:0] gc;
    logic [63:0] c;
    logic        gg;
    logic        gp;
    gc = '0;
    c  = '0;
    gg = 1'b0;
    gp = 1'b0;
    for (int k = 0; k < 15; k++) begin
      gg = w_g[4*k+3]
         | (w_p[4*k+3] & w_g[4*k+2])
         | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
         | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
      gp = &w_p[4*k +: 4];
      gc[k+1] = gg | (gp & gc[k]);
    end
    for (int k = 0; k < 16; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & c[4*k+j]);
      end
    end
    s = w_p ^ c;
  end

endmodule

module mul_booth_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned PR_W  = 64;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [OP_W-1:0]    r_m;
  logic [OP_W-1:0]    r_q;
  logic               r_qm1;
  logic [PR_W-1:0]    r_acc;
  logic [CNT_W-1:0]   r_i;
  logic               r_busy;
  logic               r_done;
  logic [OP_W-1:0]    r_hi;
  logic [OP_W-1:0]    r_lo;

  logic [1:0]         w_pair;
  logic               w_add;
  logic               w_sub;
  logic [PR_W-1:0]    w_addend;
  logic [PR_W-1:0]    w_cla_a;
  logic [PR_W-1:0]    w_cla_b;
  logic [PR_W-1:0]    w_sum;
  logic [PR_W-1:0]    w_acc_next;

  assign w_pair   = {r_q[r_i], r_qm1};
  assign w_add    = (w_pair == 2'b01);
  assign w_sub    = (w_pair == 2'b10);
  assign w_addend = {{OP_W{r_m[OP_W-1]}}, r_m} << r_i;

  // Subtraction reuses the adder: acc - x == ~(~acc + x) mod 2^64
  assign w_cla_a    = w_sub ? ~r_acc : r_acc;
  assign w_cla_b    = (w_add || w_sub) ? w_addend : '0;
  assign w_acc_next = w_sub ? ~w_sum : w_sum;

  CLA_64B u_cla (
    .a (w_cla_a),
    .b (w_cla_b),
    .s (w_sum)
  );

  // Control FSM plus datapath registers; busy/done/hi/lo are all registered
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_acc   <= '0;
      r_i     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= mcand;
            r_q     <= mplier;
            r_qm1   <= 1'b0;
            r_acc   <= '0;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_qm1 <= r_q[r_i];
          if (r_i == CNT_W'(OP_W - 1)) begin
            r_hi    <= w_acc_next[PR_W-1:OP_W];
            r_lo    <= w_acc_next[OP_W-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i <= CNT_W'(r_i + CNT_W'(1));
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= mcand;
            r_q     <= mplier;
            r_qm1   <= 1'b0;
            r_acc   <= '0;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mul_booth_seq.md
MUL_BOOTH_SEQ -- requirements
Module: mul_booth_seq

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, product width fixed at 64 bits.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 clr  input  1  asynchronous active-low clear.
REQ-005 start  input  1  request pulse; samples mcand/mplier on the same edge.
REQ-006 mcand  input  32  signed multiplicand (two's complement).
REQ-007 mplier  input  32  signed multiplier (two's complement).
REQ-008 busy  output  1  high while iterating.
REQ-009 done  output  1  single-cycle pulse; hi/lo valid.
REQ-010 hi  output  32  product bits [63:32].
REQ-011 lo  output  32  product bits [31:0].

Function
REQ-012 SHALL compute the signed 64-bit product mcand*mplier using radix-2 Booth recoding, one recoded bit per cycle.
REQ-013 SHALL perform all accumulation through one instance of CLA_64B (a, b -> s); no other adder in the datapath; the CLA_64B carry-out is unused, so arithmetic wraps mod 2^64.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: start=1 -> RUN; capture mcand and mplier; clear the 64-bit accumulator to 0; clear the 5-bit counter i to 0; set the Booth guard bit q[-1] to 0.
REQ-016 RUN, each cycle, pair = {q[i], q[i-1]}: 01 -> acc <= acc + (sext64(M) << i); 10 -> acc <= acc + (~sext64(M) + 1) << i; 00/11 -> acc <= acc + 0.
REQ-017 The negated addend SHALL be formed from the 64-bit sign-extension, so M = -2^31 negates correctly to +2^31.
REQ-018 RUN with i=31: perform the last add, then go to DONE; otherwise i <= i+1 and stay in RUN.
REQ-019 Latency: start sampled at edge E0; 32 RUN cycles; done=1 during the cycle following edge E32; done is high for exactly 1 cycle.
REQ-020 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-021 hi/lo SHALL be driven from a registered result that updates only on the RUN->DONE transition; the value is held in IDLE, DONE and RUN until the next completion.
REQ-022 DONE: start=1 -> RUN with new operands (back-to-back, no IDLE bubble); start=0 -> IDLE.
REQ-023 start while in RUN SHALL be ignored: operands, counter and accumulator are unaffected, and no request is queued.
REQ-024 Operand inputs SHALL be don't-care except on an accepted start edge.

Reset
REQ-025 clr=0 SHALL immediately force: state IDLE, busy=0, done=0, hi=0, lo=0, accumulator=0, i=0, operand registers=0.
REQ-026 clr asserted mid-RUN SHALL abandon the operation with no done pulse; after release, the first start begins a fresh 33-cycle operation.
REQ-027 start sampled on the first edge after clr release SHALL be accepted normally.

Verification
REQ-028 mcand=3, mplier=4, start 1 cycle -> busy high 32 cycles; done at cycle 33; hi=0x00000000, lo=0x0000000C.
REQ-029 mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001; mcand=0x7FFFFFFF, mplier=0xFFFFFFFF -> hi=0xFFFFFFFF, lo=0x80000001.
REQ-030 mcand=mplier=0x80000000 -> hi=0x40000000, lo=0x00000000; mcand=0x80000000, mplier=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
REQ-031 start with 5*6, then start pulses with other operands at RUN cycles 1, 10 and 31 -> single done, hi/lo=0x0/0x1E, no extra busy period.
REQ-032 clr pulsed low at RUN cycle 15 of 9*9 -> outputs 0 immediately, no done; then start 2*-3 -> done 33 cycles later, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 start held high across DONE after 7*7 -> done (49), next cycle busy=1, second result done exactly 33 cycles after first done; hi/lo held at 49 until then.
REQ-034 Random signed operand pairs (at least 1000) SHALL match a 64-bit reference product.
